link_arb: RTL and testbench

QoS-aware round-robin arbiter that merges the N_IN pipelined row (or column) links terminating at one mesh node onto that node's single X (or Y) input port. It sits between the IRS_N link pipelines of the TOPO fabric and the node input interface. It is instantiated twice per node: once for X links, once for Y links. It grants at most one flit per cycle, registers the winner into a one-deep output stage, and guards low-QoS links against starvation.

---
 rtl/topo_pkg.sv | 38 +++
 rtl/link_arb_rr_pick.sv | 47 ++++
 rtl/link_arb.sv | 161 ++++++++++++++++
 tb/tb_link_arb.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/topo_pkg.sv
// ---------------------------------------------------------------------------
// topo_pkg
// Definitions shared by the TOPO fabric link logic.
//   PYLD_W  : flit payload width {type, src, tgt, data}. It excludes vld and qos.
//   flit_t  : packed view of one payload. data occupies the low FLIT_W bits.
//   idx_w() : width needed to hold an index into n items. It returns at least 1.
// The field widths come from the fabric-wide macros `TYPE_W, `ID_W and
// `FLIT_W. If the build does not supply them, local defaults are used.
// ---------------------------------------------------------------------------
`ifndef TYPE_W
`define TYPE_W 2
`endif
`ifndef ID_W
`define ID_W 4
`endif
`ifndef FLIT_W
`define FLIT_W 32
`endif

package topo_pkg;

    localparam int FL_TYPE_W = `TYPE_W;
    localparam int FL_ID_W   = `ID_W;
    localparam int FL_DATA_W = `FLIT_W;
    localparam int PYLD_W    = `TYPE_W + 2 * `ID_W + `FLIT_W;

    typedef struct packed {
        logic [FL_TYPE_W-1:0] ftype;
        logic [FL_ID_W-1:0]   src;
        logic [FL_ID_W-1:0]   tgt;
        logic [FL_DATA_W-1:0] data;
    } flit_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/link_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. It selects the first set bit of req at
// or after ptr. The scan runs upward and wraps from N_IN-1 to 0.
// Ports:
//   req [N_IN]  : request vector.
//   ptr [IDX_W] : scan start position. It must be below N_IN.
//   gnt [N_IN]  : one-hot grant. It is all-zero when req is zero.
//   idx [IDX_W] : encoded grant index. It is 0 when req is zero.
// ---------------------------------------------------------------------------
module rr_pick
    import topo_pkg::*;
#(
    parameter int N_IN  = 7,
    parameter int IDX_W = idx_w(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_IN-1:0]  gnt,
    output logic [IDX_W-1:0] idx
);

    // Modular add without a divider. base < N_IN and off < N_IN always hold.
    function automatic int wrap(input int base, input int off);
        int s;
        s = base + off;
        return (s >= N_IN) ? s - N_IN : s;
    endfunction

    always_comb begin : p_scan
        logic found;
        int   j;
        found = 1'b0;
        j     = 0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < N_IN; k++) begin
            j = wrap(int'(ptr), k);
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/link_arb.sv
// ---------------------------------------------------------------------------
// link_arb
// QoS-aware round-robin merge of N_IN pipelined links onto one node input
// port. The block grants at most one flit per cycle. It registers the winner
// in a one-deep output stage.
//
// Optional feature macro: LINK_ARB_STARVE_EN
//   When defined, each link gets an age counter. A low-QoS link that has
//   waited AGE_MAX cycles is promoted into the high-QoS eligible set.
//   When undefined, no age counters are built and low-QoS links may starve.
//   AGE_MAX is then ignored.
//
// Ports:
//   clk, rst_n   : clock. rst_n is a synchronous, active-low reset.
//   in_vld/in_qos: per-link valid and QoS bit (1 = high).
//   in_pyld      : link i occupies bits [i*PYLD_W +: PYLD_W].
//   in_rdy       : per-link ready. It is one-hot or zero, and combinational.
//   out_vld/out_rdy           : handshake toward the node.
//   out_qos/out_pyld          : held flit, with its QoS as issued.
//   out_src_idx               : link index of the held flit.
// ---------------------------------------------------------------------------
module link_arb
    import topo_pkg::*;
#(
    parameter int N_IN    = 7,
    parameter int PYLD_W  = topo_pkg::PYLD_W,
    parameter int AGE_MAX = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_IN-1:0]          in_vld,
    output logic [N_IN-1:0]          in_rdy,
    input  logic [N_IN-1:0]          in_qos,
    input  logic [N_IN*PYLD_W-1:0]   in_pyld,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_qos,
    output logic [PYLD_W-1:0]        out_pyld,
    output logic [idx_w(N_IN)-1:0]   out_src_idx
);

    localparam int IDX_W = idx_w(N_IN);

    logic [N_IN-1:0]   promoted;
    logic [N_IN-1:0]   elig;
    logic [N_IN-1:0]   gnt;
    logic [N_IN-1:0]   acc_vec;
    logic [IDX_W-1:0]  win_idx;
    logic              slot_free;
    logic              acc;
    logic [PYLD_W-1:0] link_pyld [N_IN];

    logic              out_vld_q, out_vld_d;
    logic              out_qos_q, out_qos_d;
    logic [PYLD_W-1:0] out_pyld_q, out_pyld_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_slice
        assign link_pyld[gi] = in_pyld[gi*PYLD_W +: PYLD_W];
    end

    // While reset is held, the slot is treated as busy so that in_rdy stays zero.
    assign slot_free = rst_n & (~out_vld_q | out_rdy);

    // Promoted links compete as high-QoS. If no link qualifies, every valid
    // link competes.
    always_comb begin
        elig = in_vld & (in_qos | promoted);
        if (elig == '0) begin
            elig = in_vld;
        end
    end

    rr_pick #(
        .N_IN  (N_IN),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (elig),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .idx (win_idx)
    );

    assign in_rdy  = slot_free ? gnt : '0;
    assign acc_vec = in_vld & in_rdy;
    assign acc     = |acc_vec;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_qos_d  = out_qos_q;
        out_pyld_d = out_pyld_q;
        out_idx_d  = out_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (acc) begin
            // If the held flit drains in the same cycle, the new flit replaces it.
            out_vld_d  = 1'b1;
            out_qos_d  = in_qos[win_idx];
            out_pyld_d = link_pyld[win_idx];
            out_idx_d  = win_idx;
            rr_ptr_d   = (win_idx == IDX_W'(N_IN - 1)) ? '0 : win_idx + 1'b1;
        end else if (out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_qos_q  <= 1'b0;
            out_pyld_q <= '0;
            out_idx_q  <= '0;
            rr_ptr_q   <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_qos_q  <= out_qos_d;
            out_pyld_q <= out_pyld_d;
            out_idx_q  <= out_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

`ifdef LINK_ARB_STARVE_EN
    localparam int AGE_W = $clog2(AGE_MAX + 1);

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_age
        logic [AGE_W-1:0] age_q, age_d;

        // The counter runs only while a low-QoS flit waits. It saturates at
        // AGE_MAX.
        always_comb begin
            age_d = age_q;
            if (!in_vld[gi] || acc_vec[gi]) begin
                age_d = '0;
            end else if (!in_qos[gi] && (age_q != AGE_W'(AGE_MAX))) begin
                age_d = age_q + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                age_q <= '0;
            end else begin
                age_q <= age_d;
            end
        end

        // The comparison uses the registered count. Promotion therefore
        // applies from the cycle after the count reaches AGE_MAX.
        assign promoted[gi] = (age_q == AGE_W'(AGE_MAX));
    end
`else
    assign promoted = '0;
`endif

    assign out_vld     = out_vld_q;
    assign out_qos     = out_qos_q;
    assign out_pyld    = out_pyld_q;
    assign out_src_idx = out_idx_q;

endmodule

// File: tb/tb_link_arb.sv
// ---------------------------------------------------------------------------
// tb_link_arb
// Self-checking bench for link_arb. It applies a table of directed vectors,
// hand-written corner sequences and randomized traffic. A reference model
// derived from the arbitration rules checks the randomized traffic.
// ---------------------------------------------------------------------------
module tb_link_arb;
    import topo_pkg::*;

    localparam int N       = 7;
    localparam int PW      = topo_pkg::PYLD_W;
    localparam int AGE_MAX = 15;
    localparam int IW      = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  in_vld, in_rdy, in_qos;
    logic [N*PW-1:0] in_pyld;
    logic          out_vld, out_rdy, out_qos;
    logic [PW-1:0] out_pyld;
    logic [IW-1:0] out_src_idx;

    always #5 clk = ~clk;

    link_arb #(.N_IN(N), .PYLD_W(PW), .AGE_MAX(AGE_MAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .in_qos      (in_qos),
        .in_pyld     (in_pyld),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_qos     (out_qos),
        .out_pyld    (out_pyld),
        .out_src_idx (out_src_idx)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] pyld_of(input int i);
        flit_t f;
        f.ftype = FL_TYPE_W'(i);
        f.src   = FL_ID_W'(i);
        f.tgt   = FL_ID_W'(N - 1 - i);
        f.data  = FL_DATA_W'(32'hA1 + i);
        return f;
    endfunction

    // ---------------- reference model ----------------
    int            m_ptr;
    int            m_age [N];
    bit            m_vld, m_qos;
    logic [PW-1:0] m_pyld;
    int            m_idx;
    bit            m_acc;
    int            m_win;
    logic [N-1:0]  m_rdy;

    function automatic bit m_promoted(input int i);
`ifdef LINK_ARB_STARVE_EN
        return m_age[i] == AGE_MAX;
`else
        return (i < 0);
`endif
    endfunction

    task automatic model_comb();
        logic [N-1:0] e;
        bit free;
        free = rst_n && (!m_vld || out_rdy);
        e = '0;
        for (int i = 0; i < N; i++)
            if (in_vld[i] && (in_qos[i] || m_promoted(i))) e[i] = 1'b1;
        if (e == '0) e = in_vld;
        m_win = -1;
        for (int k = 0; k < N; k++)
            if (m_win < 0 && e[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
        m_acc = free && (m_win >= 0);
        m_rdy = '0;
        if (m_acc) m_rdy[m_win] = 1'b1;
    endtask

    task automatic model_seq();
        if (!rst_n) begin
            m_ptr = 0; m_vld = 0; m_qos = 0; m_pyld = '0; m_idx = 0;
            for (int i = 0; i < N; i++) m_age[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!in_vld[i] || (m_acc && m_win == i)) m_age[i] = 0;
                else if (!in_qos[i] && m_age[i] < AGE_MAX) m_age[i]++;
            end
            if (m_acc) begin
                m_vld  = 1;
                m_qos  = in_qos[m_win];
                m_pyld = in_pyld[m_win*PW +: PW];
                m_idx  = m_win;
                m_ptr  = (m_win + 1) % N;
            end else if (out_rdy) begin
                m_vld = 0;
            end
        end
    endtask

    // One clock: settle, optionally check in_rdy, clock edge, optionally check outputs.
    task automatic tick(input bit chk);
        #2;
        model_comb();
        if (chk) check("rdy", 64'(in_rdy), 64'(m_rdy));
        @(posedge clk);
        model_seq();
        #1;
        if (chk) begin
            check("out_vld", 64'(out_vld), 64'(m_vld));
            if (m_vld) begin
                check("out_qos", 64'(out_qos), 64'(m_qos));
                check("out_pyld", 64'(out_pyld), 64'(m_pyld));
                check("out_idx", 64'(out_src_idx), 64'(m_idx));
            end
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick(0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic         ordy;
        logic [N-1:0] vld;
        logic [N-1:0] qos;
        logic [N-1:0] exp_rdy;
        logic         exp_ov;
        int           exp_idx;
    } vec_t;

    vec_t tbl [12];

    bit            src_v [N];
    bit            src_q [N];
    logic [PW-1:0] src_p [N];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 7'b1111111, 7'b0000000, 7'b0000001, 1'b1, 0};
        tbl[1]  = '{1'b1, 7'b1111110, 7'b0000000, 7'b0000010, 1'b1, 1};
        tbl[2]  = '{1'b1, 7'b0010000, 7'b0000000, 7'b0010000, 1'b1, 4};
        tbl[3]  = '{1'b1, 7'b0100100, 7'b0000100, 7'b0000100, 1'b1, 2};
        tbl[4]  = '{1'b1, 7'b0100000, 7'b0000000, 7'b0100000, 1'b1, 5};
        tbl[5]  = '{1'b1, 7'b1000010, 7'b0000000, 7'b1000000, 1'b1, 6};
        tbl[6]  = '{1'b1, 7'b0000010, 7'b0000000, 7'b0000010, 1'b1, 1};
        tbl[7]  = '{1'b0, 7'b0000001, 7'b0000000, 7'b0000000, 1'b1, 1};
        tbl[8]  = '{1'b1, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0, 1};
        tbl[9]  = '{1'b0, 7'b0001000, 7'b0000000, 7'b0001000, 1'b1, 3};
        tbl[10] = '{1'b1, 7'b1000001, 7'b0000001, 7'b0000001, 1'b1, 0};
        tbl[11] = '{1'b1, 7'b1000001, 7'b1000001, 7'b1000000, 1'b1, 6};

        for (int i = 0; i < N; i++) in_pyld[i*PW +: PW] = pyld_of(i);

        // Reset: in_rdy stays zero even with requests; the outputs clear.
        rst_n = 1'b0; in_vld = '1; in_qos = '0; out_rdy = 1'b1;
        #2;
        check("rst_in_rdy", 64'(in_rdy), 64'd0);
        @(posedge clk);
        model_seq();
        #1;
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_out_pyld", 64'(out_pyld), 64'd0);
        check("rst_out_qos", 64'(out_qos), 64'd0);
        check("rst_out_idx", 64'(out_src_idx), 64'd0);
        rst_n = 1'b1;

        // Directed vectors.
        foreach (tbl[v]) begin
            in_vld = tbl[v].vld; in_qos = tbl[v].qos; out_rdy = tbl[v].ordy;
            #2;
            model_comb();
            check($sformatf("tbl%0d_rdy", v), 64'(in_rdy), 64'(tbl[v].exp_rdy));
            @(posedge clk);
            model_seq();
            #1;
            check($sformatf("tbl%0d_ov", v), 64'(out_vld), 64'(tbl[v].exp_ov));
            check($sformatf("tbl%0d_idx", v), 64'(out_src_idx), 64'(tbl[v].exp_idx));
            if (tbl[v].exp_ov)
                check($sformatf("tbl%0d_pyld", v), 64'(out_pyld), 64'(pyld_of(tbl[v].exp_idx)));
        end

        // Reset with a held flit: the flit is dropped and the pointer returns to 0.
        in_vld = 7'b0110100; in_qos = '0; out_rdy = 1'b1;
        tick(0);                         // link 2 wins, pointer moves to 3
        out_rdy = 1'b0;
        tick(0);                         // the flit is held
        rst_n = 1'b0;
        #2;
        check("rst2_in_rdy", 64'(in_rdy), 64'd0);
        @(posedge clk);
        model_seq();
        #1;
        check("rst2_out_vld", 64'(out_vld), 64'd0);
        check("rst2_out_idx", 64'(out_src_idx), 64'd0);
        rst_n = 1'b1; out_rdy = 1'b1;
        #2;
        model_comb();
        check("rst2_first_rdy", 64'(in_rdy), 64'(7'b0000100));
        @(posedge clk);
        model_seq();
        #1;
        check("rst2_first_idx", 64'(out_src_idx), 64'd2);

        // Throughput: all links valid with qos=0 give grants 0..6,0 back to back.
        pulse_reset();
        in_vld = '1; in_qos = '0; out_rdy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #2;
            model_comb();
            check($sformatf("tp%0d_rdy", c), 64'(in_rdy), 64'(1) << (c % N));
            @(posedge clk);
            model_seq();
            #1;
            check($sformatf("tp%0d_ov", c), 64'(out_vld), 64'd1);
            check($sformatf("tp%0d_idx", c), 64'(out_src_idx), 64'(c % N));
        end

        // Backpressure: hold for 4 cycles, then replace the flit in the drain cycle.
        out_rdy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #2;
            model_comb();
            check($sformatf("bp%0d_rdy", c), 64'(in_rdy), 64'd0);
            @(posedge clk);
            model_seq();
            #1;
            check($sformatf("bp%0d_ov", c), 64'(out_vld), 64'd1);
            check($sformatf("bp%0d_idx", c), 64'(out_src_idx), 64'd0);
            check($sformatf("bp%0d_pyld", c), 64'(out_pyld), 64'(pyld_of(0)));
        end
        out_rdy = 1'b1;
        #2;
        model_comb();
        check("bp_release_rdy", 64'(in_rdy), 64'(7'b0000010));
        @(posedge clk);
        model_seq();
        #1;
        check("bp_release_ov", 64'(out_vld), 64'd1);
        check("bp_release_idx", 64'(out_src_idx), 64'd1);

        // Starvation: link 2 is high-QoS and link 5 is low-QoS, both continuous.
        begin
            int n5, first5;
            pulse_reset();
            in_vld = 7'b0100100; in_qos = 7'b0000100; out_rdy = 1'b1;
            n5 = 0; first5 = -1;
            for (int c = 0; c < 40; c++) begin
                tick(1);
                if (out_vld && out_src_idx == 3'd5) begin
                    n5++;
                    if (first5 < 0) first5 = c;
                end
            end
`ifdef LINK_ARB_STARVE_EN
            check("starve_count", 64'(n5), 64'd2);
            check("starve_first", 64'(first5), 64'd15);
`else
            check("starve_count", 64'(n5), 64'd0);
`endif
        end

        // Randomized traffic against the model. Each source holds its flit until accepted.
        pulse_reset();
        for (int i = 0; i < N; i++) src_v[i] = 0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!src_v[i] && $urandom_range(0, 2) == 0) begin
                    logic [63:0] r;
                    r = {$urandom(), $urandom()};
                    src_v[i] = 1;
                    src_q[i] = ($urandom_range(0, 3) == 0);
                    src_p[i] = r[PW-1:0];
                end
                in_vld[i] = src_v[i];
                in_qos[i] = src_v[i] ? src_q[i] : 1'b0;
                in_pyld[i*PW +: PW] = src_p[i];
            end
            out_rdy = ($urandom_range(0, 3) != 0);
            tick(1);
            if (m_acc) src_v[m_win] = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
